// File: rtl/ps2_key_sender_pkg.sv
// Shared constants, state encoding and the ASCII to scan-code lookup
// for the PS/2 key sender.
package ps2_key_sender_pkg;

  localparam logic [7:0] ASCII_W = 8'd87;
  localparam logic [7:0] ASCII_S = 8'd83;
  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_D = 8'd68;

  localparam logic [7:0] SCAN_W = 8'h1D;
  localparam logic [7:0] SCAN_S = 8'h1B;
  localparam logic [7:0] SCAN_A = 8'h1C;
  localparam logic [7:0] SCAN_D = 8'h23;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } senderState_t;

  typedef struct packed {
    logic       mapped;
    logic [7:0] code;
  } scanLookup_t;

  function automatic scanLookup_t mapAscii(input logic [7:0] ascii);
    scanLookup_t result;
    result.mapped = 1'b1;
    case (ascii)
      ASCII_W: result.code = SCAN_W;
      ASCII_S: result.code = SCAN_S;
      ASCII_A: result.code = SCAN_A;
      ASCII_D: result.code = SCAN_D;
      default: begin
        result.mapped = 1'b0;
        result.code   = 8'h00;
      end
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ps2_key_sender_if.sv
// Key request handshake between a key source (master) and the PS/2 sender (slave).
interface ps2_key_sender_if;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_release;
  logic       ready;
  logic       bad_key;

  modport master (
    output key_valid,
    output key_ascii,
    output key_release,
    input  ready,
    input  bad_key
  );

  modport slave (
    input  key_valid,
    input  key_ascii,
    input  key_release,
    output ready,
    output bad_key
  );
endinterface

// File: rtl/ps2_frame_tx.sv
// Serializes one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop).
// start_i is taken only while idle; done_o marks the last cycle of the stop bit.
module ps2_frame_tx
  import ps2_key_sender_pkg::*;
#(
  parameter int HALF_PERIOD = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HALF_MAX = CW'(HALF_PERIOD - 1);

  logic                  busy_q, busy_d;
  logic                  lowPhase_q, lowPhase_d;
  logic [CW-1:0]         halfCnt_q, halfCnt_d;
  logic [3:0]            bitIdx_q, bitIdx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  ps2Clk_q, ps2Clk_d;
  logic                  ps2Data_q, ps2Data_d;
  logic                  halfEnd;
  logic                  lastBit;

  assign halfEnd = busy_q && (halfCnt_q == HALF_MAX);
  assign lastBit = (bitIdx_q == 4'd10);
  assign done_o  = halfEnd && lowPhase_q && lastBit;

  // Each bit: data changes at bit start, clock high then low for one half each.
  always_comb begin
    busy_d     = busy_q;
    lowPhase_d = lowPhase_q;
    halfCnt_d  = halfCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    ps2Clk_d   = ps2Clk_q;
    ps2Data_d  = ps2Data_q;
    if (busy_q) begin
      halfCnt_d = halfEnd ? '0 : halfCnt_q + 1'b1;
      if (halfEnd) begin
        if (!lowPhase_q) begin
          lowPhase_d = 1'b1;
          ps2Clk_d   = 1'b0;
        end else begin
          lowPhase_d = 1'b0;
          ps2Clk_d   = 1'b1;
          if (lastBit) begin
            busy_d    = 1'b0;
            bitIdx_d  = 4'd0;
            ps2Data_d = 1'b1;
          end else begin
            bitIdx_d  = bitIdx_q + 4'd1;
            shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            ps2Data_d = shift_q[1];
          end
        end
      end
    end else if (start_i) begin
      busy_d     = 1'b1;
      lowPhase_d = 1'b0;
      halfCnt_d  = '0;
      bitIdx_d   = 4'd0;
      shift_d    = {1'b1, ~^data_i, data_i, 1'b0};
      ps2Clk_d   = 1'b1;
      ps2Data_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q     <= 1'b0;
      lowPhase_q <= 1'b0;
      halfCnt_q  <= '0;
      bitIdx_q   <= 4'd0;
      shift_q    <= '1;
      ps2Clk_q   <= 1'b1;
      ps2Data_q  <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      lowPhase_q <= lowPhase_d;
      halfCnt_q  <= halfCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      ps2Clk_q   <= ps2Clk_d;
      ps2Data_q  <= ps2Data_d;
    end
  end

  assign ps2_clk_o  = ps2Clk_q;
  assign ps2_data_o = ps2Data_q;

endmodule

// File: rtl/ps2_key_sender.sv
// Maps an ASCII key request to a PS/2 make or break sequence and sequences
// the frames and inter-frame gaps through ps2_frame_tx.
module ps2_key_sender
  import ps2_key_sender_pkg::*;
#(
  parameter int HALF_PERIOD = 2500
) (
  input  logic              clock,
  input  logic              reset,
  ps2_key_sender_if.slave   keyIf,
  output logic              ps2_clk,
  output logic              ps2_data
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HALF_MAX = CW'(HALF_PERIOD - 1);

  senderState_t  state_q;
  logic          ready_q;
  logic          badKey_q;
  logic          pending_q;
  logic [7:0]    scanCode_q;
  logic [CW-1:0] halfCnt_q;
  logic          gapHalf_q;

  scanLookup_t   lookup;
  logic          accept;
  logic          gapEnd;
  logic          frameStart;
  logic [7:0]    frameData;
  logic          frameDone;

  assign lookup = mapAscii(keyIf.key_ascii);
  assign accept = ready_q && keyIf.key_valid;
  assign gapEnd = (state_q == GAP) && gapHalf_q && (halfCnt_q == HALF_MAX);

  // A break sends F0 first; the latched scan code follows after the gap.
  assign frameStart = (accept && lookup.mapped) || (gapEnd && pending_q);
  assign frameData  = (state_q == GAP) ? scanCode_q
                    : (keyIf.key_release ? BREAK_CODE : lookup.code);

  ps2_frame_tx #(
    .HALF_PERIOD(HALF_PERIOD)
  ) frameTx (
    .clock     (clock),
    .reset     (reset),
    .start_i   (frameStart),
    .data_i    (frameData),
    .done_o    (frameDone),
    .ps2_clk_o (ps2_clk),
    .ps2_data_o(ps2_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      badKey_q   <= 1'b0;
      pending_q  <= 1'b0;
      scanCode_q <= 8'h00;
      halfCnt_q  <= '0;
      gapHalf_q  <= 1'b0;
    end else begin
      badKey_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (lookup.mapped) begin
              scanCode_q <= lookup.code;
              pending_q  <= keyIf.key_release;
              ready_q    <= 1'b0;
              state_q    <= SEND;
            end else begin
              badKey_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (frameDone) begin
            state_q   <= GAP;
            halfCnt_q <= '0;
            gapHalf_q <= 1'b0;
          end
        end
        GAP: begin
          if (halfCnt_q == HALF_MAX) begin
            halfCnt_q <= '0;
            if (gapHalf_q) begin
              gapHalf_q <= 1'b0;
              if (pending_q) begin
                pending_q <= 1'b0;
                state_q   <= SEND;
              end else begin
                ready_q <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              gapHalf_q <= 1'b1;
            end
          end else begin
            halfCnt_q <= halfCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign keyIf.ready   = ready_q;
  assign keyIf.bad_key = badKey_q;

endmodule

// File: tb/tb_ps2_key_sender.sv
// Directed, table-driven bench for ps2_key_sender at HALF_PERIOD=2.
module tb_ps2_key_sender;

  localparam int HP = 2;

  typedef struct {
    logic [7:0]  ascii;
    logic        rel;
    logic        bad;
    int          nFrames;
    logic [10:0] frame0;
    logic [10:0] frame1;
    int          lowCycles;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic ps2Clk;
  logic ps2Data;

  ps2_key_sender_if keyIf ();

  ps2_key_sender #(
    .HALF_PERIOD(HP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .keyIf   (keyIf),
    .ps2_clk (ps2Clk),
    .ps2_data(ps2Data)
  );

  // 10 ns system clock.
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  vec_t vecs [8];

  // Hard time limit so a stuck design still terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] ascii, input logic rel);
    keyIf.key_valid   = valid;
    keyIf.key_ascii   = ascii;
    keyIf.key_release = rel;
  endtask

  // Accepts one request from idle and follows the whole sequence cycle by cycle.
  task automatic runSequence(input vec_t v, input logic holdValid, input string tag);
    logic [10:0] expFrame;
    logic [10:0] got;
    logic [3:0]  clkPat;
    logic [3:0]  dataPat;
    logic [7:0]  gapPat;
    logic        idleOk;
    int          low;
    applyStimulus(1'b1, v.ascii, v.rel);
    step();
    applyStimulus(holdValid, holdValid ? 8'd83 : 8'd0, ~v.rel);
    if (v.bad) begin
      checkOutput({tag, " bad_key pulse"}, 32'(keyIf.bad_key), 32'd1);
      checkOutput({tag, " ready on bad"}, 32'(keyIf.ready), 32'd1);
      checkOutput({tag, " lines on bad"}, 32'({ps2Clk, ps2Data}), 32'h3);
      step();
      checkOutput({tag, " bad_key cleared"}, 32'(keyIf.bad_key), 32'd0);
      checkOutput({tag, " lines after bad"}, 32'({ps2Clk, ps2Data, keyIf.ready}), 32'h7);
      return;
    end
    checkOutput({tag, " bad_key quiet"}, 32'(keyIf.bad_key), 32'd0);
    low = 0;
    for (int f = 0; f < v.nFrames; f++) begin
      expFrame = (f == 0) ? v.frame0 : v.frame1;
      got = '0;
      for (int b = 0; b < 11; b++) begin
        clkPat  = '0;
        dataPat = '0;
        for (int c = 0; c < 4; c++) begin
          clkPat[3-c]  = ps2Clk;
          dataPat[3-c] = ps2Data;
          if (!keyIf.ready) low++;
          step();
        end
        got[b] = dataPat[3];
        checkOutput($sformatf("%s f%0d b%0d clk", tag, f, b), 32'(clkPat), 32'hC);
        checkOutput($sformatf("%s f%0d b%0d data", tag, f, b), 32'(dataPat),
                    32'({4{expFrame[b]}}));
      end
      gapPat = '0;
      for (int c = 0; c < 4; c++) begin
        gapPat[7-2*c] = ps2Clk;
        gapPat[6-2*c] = ps2Data;
        if (!keyIf.ready) low++;
        if (f == v.nFrames - 1 && c == 3) keyIf.key_valid = 1'b0;
        step();
      end
      checkOutput($sformatf("%s f%0d gap lines", tag, f), 32'(gapPat), 32'hFF);
      checkOutput($sformatf("%s f%0d frame", tag, f), 32'(got), 32'(expFrame));
      checkOutput($sformatf("%s f%0d odd parity", tag, f), 32'($countones(got[9:1]) % 2), 32'd1);
    end
    checkOutput({tag, " ready returns"}, 32'(keyIf.ready), 32'd1);
    checkOutput({tag, " ready low cycles"}, 32'(low), 32'(v.lowCycles));
    idleOk = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (!(keyIf.ready && ps2Clk && ps2Data)) idleOk = 1'b0;
      step();
    end
    checkOutput({tag, " idle afterwards"}, 32'(idleOk), 32'd1);
  endtask

  initial begin
    // Frames listed as {stop, parity, data, start}; bit 0 is sent first.
    vecs[0] = '{8'd87,  1'b0, 1'b0, 1, {1'b1, 1'b1, 8'h1D, 1'b0}, 11'h0, 48};
    vecs[1] = '{8'd83,  1'b0, 1'b0, 1, {1'b1, 1'b1, 8'h1B, 1'b0}, 11'h0, 48};
    vecs[2] = '{8'd65,  1'b0, 1'b0, 1, {1'b1, 1'b0, 8'h1C, 1'b0}, 11'h0, 48};
    vecs[3] = '{8'd68,  1'b0, 1'b0, 1, {1'b1, 1'b0, 8'h23, 1'b0}, 11'h0, 48};
    vecs[4] = '{8'd65,  1'b1, 1'b0, 2, {1'b1, 1'b1, 8'hF0, 1'b0},
                {1'b1, 1'b0, 8'h1C, 1'b0}, 96};
    vecs[5] = '{8'd87,  1'b1, 1'b0, 2, {1'b1, 1'b1, 8'hF0, 1'b0},
                {1'b1, 1'b1, 8'h1D, 1'b0}, 96};
    vecs[6] = '{8'd66,  1'b0, 1'b1, 0, 11'h0, 11'h0, 0};
    vecs[7] = '{8'd119, 1'b1, 1'b1, 0, 11'h0, 11'h0, 0};

    // Reset with a request held: it must be ignored.
    reset = 1'b1;
    applyStimulus(1'b1, 8'd68, 1'b0);
    repeat (3) step();
    checkOutput("reset ready", 32'(keyIf.ready), 32'd1);
    checkOutput("reset bad_key", 32'(keyIf.bad_key), 32'd0);
    checkOutput("reset ps2_clk", 32'(ps2Clk), 32'd1);
    checkOutput("reset ps2_data", 32'(ps2Data), 32'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (3) step();
    checkOutput("post-reset idle", 32'({keyIf.ready, ps2Clk, ps2Data}), 32'h7);

    for (int i = 0; i < 8; i++) begin
      runSequence(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Request for 83 held throughout a 68 transmission is ignored.
    runSequence(vecs[3], 1'b1, "hold83");

    // Reset at bit 5 aborts the frame; a fresh request then sends cleanly.
    applyStimulus(1'b1, 8'd68, 1'b0);
    step();
    applyStimulus(1'b0, 8'd0, 1'b0);
    repeat (20) step();
    checkOutput("midframe busy", 32'({keyIf.ready, ps2Clk, ps2Data}), 32'h2);
    reset = 1'b1;
    step();
    checkOutput("abort lines", 32'({ps2Clk, ps2Data}), 32'h3);
    checkOutput("abort ready", 32'(keyIf.ready), 32'd1);
    reset = 1'b0;
    step();
    runSequence(vecs[3], 1'b0, "afterAbort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_sender.md
PS2_KEY_SENDER -- requirements
Module: ps2_key_sender

Interface
REQ-001 The block SHALL have one parameter: HALF_PERIOD, default 2500, system clock cycles per PS/2 clock half-period (minimum 2).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_valid  input  1  request strobe; sampled only while ready=1.
REQ-006 key_ascii  input  8  ASCII code of the key: W=87, S=83, A=65, D=68.
REQ-007 key_release  input  1  0 = send make code; 1 = send break sequence (F0 then the scan code).
REQ-008 ready  output  1  high when idle and able to accept a request.
REQ-009 bad_key  output  1  one-cycle pulse when an accepted ASCII code is unmapped.
REQ-010 ps2_clk  output  1  PS/2 clock line, idle high.
REQ-011 ps2_data  output  1  PS/2 data line, idle high.

Function
REQ-012 Mapping SHALL be: 87->8'h1D, 83->8'h1B, 65->8'h1C, 68->8'h23; all other codes are unmapped.
REQ-013 Accept: key_valid=1 while ready=1; key_valid while ready=0 SHALL be ignored, with no queuing.
REQ-014 An accepted unmapped code SHALL assert bad_key for exactly the next cycle; ready stays 1 and no frame is sent.
REQ-015 An accepted mapped code SHALL drop ready in the next cycle, and ready stays 0 until the sequence and its trailing gap complete.
REQ-016 Frame format SHALL be 11 bits, in this order: start 0; d0..d7 (LSB first); odd parity (~^data); stop 1.
REQ-017 Bit timing for each bit: ps2_data set at bit start; ps2_clk=1 for HALF_PERIOD cycles, then ps2_clk=0 for HALF_PERIOD cycles; one bit = 2*HALF_PERIOD cycles.
REQ-018 The first frame's start bit SHALL appear on ps2_data in the cycle after accept.
REQ-019 After every frame: gap of 2*HALF_PERIOD cycles with ps2_clk=1 and ps2_data=1.
REQ-020 Make sequence SHALL be one frame plus one gap, 24*HALF_PERIOD cycles; ready returns to 1 in the following cycle.
REQ-021 Break sequence SHALL be an F0 frame, gap, scan-code frame, gap, 48*HALF_PERIOD cycles; ready then returns to 1.
REQ-022 State machine SHALL have states IDLE, SEND, GAP, with transitions:
- IDLE->SEND on a mapped accept;
- SEND->GAP after bit 10 completes;
- GAP->SEND if the make frame is still pending after F0;
- GAP->IDLE otherwise.
REQ-023 Internal counters:
- Half-period counter counts 0..HALF_PERIOD-1 and wraps to 0.
- Bit index counts 0..10 and SHALL NOT exceed 10.
REQ-024 The scan code and key_release SHALL be latched at accept; input changes during a transmission have no effect.
REQ-025 Outputs SHALL be registered; no combinational path from inputs to ps2_clk/ps2_data.

Reset
REQ-026 Reset values: state=IDLE; ready=1; bad_key=0; ps2_clk=1; ps2_data=1; counters=0; pending flag=0.
REQ-027 Reset asserted mid-frame SHALL abort the transmission; both PS/2 lines are high from the first cycle after the reset edge, with no partial frame resumed.
REQ-028 key_valid during a reset cycle SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold:
- ASCII constants 87/83/65/68;
- scan codes 1D/1B/1C/23;
- BREAK_CODE 8'hF0;
- state enum {IDLE, SEND, GAP}.
REQ-030 One sub-module, ps2_frame_tx, SHALL serialize one 11-bit frame with its own start and done handshake; the top level holds the mapping and sequencing.

Verification (HALF_PERIOD=2)
REQ-031 Accept 87, release=0 -> ps2_data bits: 0,1,0,1,1,1,0,0,0,1,1, each held 4 cycles (clock 1,1,0,0); ready low for 48 cycles, then high.
REQ-032 Accept 65, release=1 -> F0 frame 0,0,0,0,0,1,1,1,1,1,1; 4-cycle gap; 1C frame 0,0,0,1,1,1,0,0,0,0,1; ready low for 96 cycles.
REQ-033 Accept 66 -> bad_key high for exactly 1 cycle; ready stays 1; lines stay high.
REQ-034 key_valid=1 with 83 held during a 68 transmission -> only the 23 frame is sent; the 83 is not sent afterwards unless key_valid is still high when ready returns to 1.
REQ-035 Reset asserted at bit 5 of a frame -> next cycle ps2_clk=1, ps2_data=1, ready=1; a new request of 68 then sends a clean 23 frame.
REQ-036 Parity check for all four keys and F0 -> odd count of ones across the data and parity bits.
